// File: rtl/mu0_mem_responder.sv
// mu0_mem_responder: memory-side responder for the MU0 processor bus.
// Services word-addressed RAM reads/writes with WAIT_STATES extra cycles
// before a single-cycle Ready strobe.
//
// Parameters:
//   DEPTH_LOG2   RAM depth = 2**DEPTH_LOG2 words; upper Address bits alias
//   WAIT_STATES  extra cycles inserted before Ready (0..15)
// Ports:
//   Clk       system clock
//   Reset     synchronous active-low reset
//   Address   word address from CPU
//   Data_out  write data from CPU
//   Rd, Wr    read / write requests, held until Ready
//   Data_in   read data to CPU (holds until the next read)
//   Ready     one-cycle completion strobe
//   Busy      high while an access is in progress
//   Io_out    memory-mapped output register at 12'hFFF
// Configuration macro:
//   MU0_MEM_IO_EN  decode 12'hFFF as the Io_out register; otherwise Io_out is 0
module mu0_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [11:0] Address,
  input  logic [15:0] Data_out,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] Data_in,
  output logic        Ready,
  output logic        Busy,
  output logic [15:0] Io_out
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;
  logic                cap_wr_q, cap_wr_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]     eff_addr_c;
  logic [DATA_W-1:0]     eff_data_c;
  logic                  eff_wr_c;
  logic                  enter_resp_c;
  logic                  io_hit_c;
  logic                  mem_we_c;
  logic [DEPTH_LOG2-1:0] mem_idx_c;
  logic [DATA_W-1:0]     rd_data_c;

`ifdef MU0_MEM_IO_EN
  logic [DATA_W-1:0]   io_out_q, io_out_d;
`endif

  // Next-state, capture and access logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    cap_wr_d   = cap_wr_q;
    data_in_d  = data_in_q;
    rd_data_c  = '0;
    io_hit_c   = 1'b0;
    mem_we_c   = 1'b0;
`ifdef MU0_MEM_IO_EN
    io_out_d   = io_out_q;
`endif

    // With zero wait states the access completes on the accepting edge,
    // so live inputs are used in IDLE and the captured copies afterwards.
    if (state_q == S_IDLE) begin
      eff_addr_c = Address;
      eff_data_c = Data_out;
      eff_wr_c   = Wr;
    end else begin
      eff_addr_c = cap_addr_q;
      eff_data_c = cap_data_q;
      eff_wr_c   = cap_wr_q;
    end
    mem_idx_c = eff_addr_c[DEPTH_LOG2-1:0];

    case (state_q)
      S_IDLE: begin
        if (Rd || Wr) begin
          cap_addr_d = Address;
          cap_data_d = Data_out;
          cap_wr_d   = Wr;  // Rd and Wr together is a write
          cnt_d      = CNT_W'(WAIT_STATES);
          state_d    = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    enter_resp_c = (state_d == S_RESP) && (state_q != S_RESP);

`ifdef MU0_MEM_IO_EN
    io_hit_c = (eff_addr_c == ADDR_W'(12'hFFF));
`endif
    rd_data_c = io_hit_c ? Io_out : mem[mem_idx_c];

    if (enter_resp_c) begin
      if (eff_wr_c) begin
        mem_we_c = !io_hit_c && Reset;
`ifdef MU0_MEM_IO_EN
        if (io_hit_c) io_out_d = eff_data_c;
`endif
      end else begin
        data_in_d = rd_data_c;
      end
    end

    ready_d = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
  end

  // Control and output registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      cap_wr_q   <= 1'b0;
      data_in_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MU0_MEM_IO_EN
      io_out_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      cap_wr_q   <= cap_wr_d;
      data_in_q  <= data_in_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef MU0_MEM_IO_EN
      io_out_q   <= io_out_d;
`endif
    end
  end

  // RAM array: contents survive reset
  always_ff @(posedge Clk) begin
    if (mem_we_c) mem[mem_idx_c] <= eff_data_c;
  end

  assign Data_in = data_in_q;
  assign Ready   = ready_q;
  assign Busy    = busy_q;
`ifdef MU0_MEM_IO_EN
  assign Io_out  = io_out_q;
`else
  assign Io_out  = '0;
`endif

endmodule

// File: tb/tb_mu0_mem_responder.sv
// Directed bench for mu0_mem_responder: one instance with 2 wait states and a
// full 4K RAM, one with 0 wait states and a 16-word RAM to exercise aliasing.
module tb_mu0_mem_responder;

  logic        Clk;
  logic        Reset;

  logic [11:0] a_addr, b_addr;
  logic [15:0] a_dout, b_dout;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [15:0] a_din, b_din, a_io, b_io;
  logic        a_rdy, b_rdy, a_busy, b_busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ma [int];
  logic [15:0] mb [int];
  logic [15:0] sbq_a [$];
  logic [15:0] sbq_b [$];
  logic [15:0] exp_din_a, exp_din_b, exp_io_a, exp_io_b;

  mu0_mem_responder #(.DEPTH_LOG2(12), .WAIT_STATES(2)) dut_a (
    .Clk(Clk), .Reset(Reset), .Address(a_addr), .Data_out(a_dout),
    .Rd(a_rd), .Wr(a_wr), .Data_in(a_din), .Ready(a_rdy), .Busy(a_busy),
    .Io_out(a_io)
  );

  mu0_mem_responder #(.DEPTH_LOG2(4), .WAIT_STATES(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .Address(b_addr), .Data_out(b_dout),
    .Rd(b_rd), .Wr(b_wr), .Data_in(b_din), .Ready(b_rdy), .Busy(b_busy),
    .Io_out(b_io)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit io_addr(input logic [11:0] addr);
`ifdef MU0_MEM_IO_EN
    return addr == 12'hFFF;
`else
    return 1'b0;
`endif
  endfunction

  // Update the reference model for a write to the given instance
  task automatic model_write(input bit sel_b, input logic [11:0] addr, input logic [15:0] data);
    if (io_addr(addr)) begin
      if (sel_b) exp_io_b = data; else exp_io_a = data;
    end else if (sel_b) mb[int'(addr[3:0])] = data;
    else ma[int'(addr)] = data;
  endtask

  function automatic logic [15:0] model_read(input bit sel_b, input logic [11:0] addr);
    if (io_addr(addr)) return sel_b ? exp_io_b : exp_io_a;
    if (sel_b) return mb[int'(addr[3:0])];
    return ma[int'(addr)];
  endfunction

  // Wait (bounded) for Ready; lat = cycles counted, -1 on timeout
  task automatic wait_rdy(input bit sel_b, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if ((sel_b ? b_rdy : a_rdy) === 1'b1) begin
        lat = i;
        break;
      end
      if (i == 1 && !sel_b) chk("busy_in_wait", 32'(a_busy), 32'd1);
    end
  endtask

  // Complete one access and check latency, data, Ready width and Io_out
  task automatic access(input bit sel_b, input logic rd, input logic wr,
                        input logic [11:0] addr, input logic [15:0] data);
    int lat;
    logic [15:0] e;
    if (wr) model_write(sel_b, addr, data);
    else if (sel_b) sbq_b.push_back(model_read(1'b1, addr));
    else sbq_a.push_back(model_read(1'b0, addr));
    @(negedge Clk);
    if (sel_b) begin b_rd = rd; b_wr = wr; b_addr = addr; b_dout = data; end
    else       begin a_rd = rd; a_wr = wr; a_addr = addr; a_dout = data; end
    wait_rdy(sel_b, lat);
    if (sel_b) begin b_rd = 1'b0; b_wr = 1'b0; end
    else       begin a_rd = 1'b0; a_wr = 1'b0; end
    chk("latency", 32'(lat), sel_b ? 32'd1 : 32'd3);
    if (!wr) begin
      if (sel_b) begin e = sbq_b.pop_front(); exp_din_b = e; end
      else       begin e = sbq_a.pop_front(); exp_din_a = e; end
    end
    chk("data_in", 32'(sel_b ? b_din : a_din), 32'(sel_b ? exp_din_b : exp_din_a));
    @(negedge Clk);
    chk("ready_single", 32'(sel_b ? b_rdy : a_rdy), 32'd0);
    chk("busy_idle", 32'(sel_b ? b_busy : a_busy), 32'd0);
    chk("io_out", 32'(sel_b ? b_io : a_io), 32'(sel_b ? exp_io_b : exp_io_a));
  endtask

  initial begin
    int lat;
    int seen;
    Reset = 1'b0;
    a_addr = '0; a_dout = '0; a_rd = 1'b0; a_wr = 1'b0;
    b_addr = '0; b_dout = '0; b_rd = 1'b0; b_wr = 1'b0;
    exp_din_a = '0; exp_din_b = '0; exp_io_a = '0; exp_io_b = '0;

    repeat (3) @(negedge Clk);
    chk("rst_ready_a", 32'(a_rdy), 32'd0);
    chk("rst_busy_a", 32'(a_busy), 32'd0);
    chk("rst_din_a", 32'(a_din), 32'd0);
    chk("rst_io_a", 32'(a_io), 32'd0);
    chk("rst_din_b", 32'(b_din), 32'd0);
    chk("rst_io_b", 32'(b_io), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Write then read with two wait states
    access(1'b0, 1'b0, 1'b1, 12'h010, 16'h1234);
    access(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000);

    // Rd and Wr together act as a write; Data_in keeps 0x1234
    access(1'b0, 1'b1, 1'b1, 12'h020, 16'h5A5A);
    chk("rdwr_din_hold", 32'(a_din), 32'h1234);
    access(1'b0, 1'b1, 1'b0, 12'h020, 16'h0000);

    // Inputs changed during WAIT are ignored
    access(1'b0, 1'b0, 1'b1, 12'h031, 16'h7777);
    model_write(1'b0, 12'h030, 16'hBEEF);
    @(negedge Clk);
    a_wr = 1'b1; a_addr = 12'h030; a_dout = 16'hBEEF;
    @(negedge Clk);
    a_addr = 12'h031; a_dout = 16'h0000;
    wait_rdy(1'b0, lat);
    a_wr = 1'b0;
    chk("capture_latency", 32'(lat), 32'd2);
    @(negedge Clk);
    access(1'b0, 1'b1, 1'b0, 12'h030, 16'h0000);
    access(1'b0, 1'b1, 1'b0, 12'h031, 16'h0000);

    // Reset during WAIT aborts the access
    access(1'b0, 1'b0, 1'b1, 12'h040, 16'h1111);
    @(negedge Clk);
    a_wr = 1'b1; a_addr = 12'h040; a_dout = 16'h2222;
    @(negedge Clk);
    chk("abort_busy_before", 32'(a_busy), 32'd1);
    Reset = 1'b0; a_wr = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    exp_din_a = '0; exp_din_b = '0; exp_io_a = '0; exp_io_b = '0;
    chk("abort_ready", 32'(a_rdy), 32'd0);
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_din", 32'(a_din), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (a_rdy === 1'b1) seen++;
    end
    chk("abort_no_ready", 32'(seen), 32'd0);
    access(1'b0, 1'b1, 1'b0, 12'h040, 16'h0000);

    // Top address: Io_out register or plain RAM depending on build
    access(1'b0, 1'b0, 1'b1, 12'hFFF, 16'h00C3);
    access(1'b0, 1'b1, 1'b0, 12'hFFF, 16'h0000);

    // Zero wait states, back-to-back write then read, spacing 2 cycles
    model_write(1'b1, 12'h001, 16'hAAAA);
    @(negedge Clk);
    b_wr = 1'b1; b_addr = 12'h001; b_dout = 16'hAAAA;
    wait_rdy(1'b1, lat);
    chk("b2b_wr_latency", 32'(lat), 32'd1);
    sbq_b.push_back(model_read(1'b1, 12'h001));
    b_wr = 1'b0; b_rd = 1'b1;
    wait_rdy(1'b1, lat);
    b_rd = 1'b0;
    chk("b2b_spacing", 32'(lat), 32'd2);
    exp_din_b = sbq_b.pop_front();
    chk("b2b_rd_data", 32'(b_din), 32'(exp_din_b));
    @(negedge Clk);

    // Aliasing on the 16-word instance
    access(1'b1, 1'b0, 1'b1, 12'h013, 16'h3C3C);
    access(1'b1, 1'b1, 1'b0, 12'h003, 16'h0000);
    access(1'b1, 1'b1, 1'b0, 12'h0F1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
